// File: rtl/debug_pkg.sv
// debug_pkg: shared state encoding, default widths and select-width helper for the debug probe bank
package debug_pkg;
  typedef enum logic [1:0] {LIVE = 2'd0, ARMED = 2'd1, POST = 2'd2, FROZEN = 2'd3} state_t;
  localparam int DEF_SEQ_LEN = 16;
  localparam int DEF_SEQ_NUM = 17;
  localparam int DEF_CH_NUM = DEF_SEQ_NUM;
  function automatic int sel_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/debug_probe_bank_if.sv
// debug_probe_bank_if: probe inputs, capture controls and display outputs of the debug probe bank
interface debug_probe_bank_if #(
  parameter int SEQ_LEN = debug_pkg::DEF_SEQ_LEN,
  parameter int CH_NUM = debug_pkg::DEF_CH_NUM,
  parameter int HIST_DEPTH = 8,
  parameter int PAGE_SIZE = 4
);
  import debug_pkg::*;
  localparam int CH_W = sel_w(CH_NUM);
  localparam int HW = $clog2(HIST_DEPTH + 1);
  logic [CH_NUM*SEQ_LEN-1:0] probe_in;
  logic [CH_NUM-1:0] probe_signed;
  logic freeze_req, resume, arm, clr_stats;
  logic [CH_W-1:0] trig_ch, hist_ch, page_sel;
  logic [SEQ_LEN-1:0] trig_val;
  logic [CH_NUM*SEQ_LEN-1:0] snap_out, min_out, max_out;
  logic [HIST_DEPTH*SEQ_LEN-1:0] hist_out;
  logic [HW-1:0] hist_cnt;
  logic [PAGE_SIZE*SEQ_LEN-1:0] page_out;
  logic [1:0] state_out;
  logic trig_hit;
  modport master (
    output probe_in, probe_signed, freeze_req, resume, arm, clr_stats, trig_ch, trig_val, hist_ch, page_sel,
    input snap_out, min_out, max_out, hist_out, hist_cnt, page_out, state_out, trig_hit
  );
  modport slave (
    input probe_in, probe_signed, freeze_req, resume, arm, clr_stats, trig_ch, trig_val, hist_ch, page_sel,
    output snap_out, min_out, max_out, hist_out, hist_cnt, page_out, state_out, trig_hit
  );
endinterface

// File: rtl/probe_stat_cell.sv
// probe_stat_cell: one channel's running min/max with a valid flag and signed/unsigned compare
module probe_stat_cell #(
  parameter int W = 16
) (
  input  logic         debug_char_clk,
  input  logic         sys_rst_n,
  input  logic         clr,
  input  logic         cap,
  input  logic         sgn,
  input  logic [W-1:0] d,
  output logic [W-1:0] mn,
  output logic [W-1:0] mx
);
  logic valid, lt, gt;
  always_comb begin
    lt = sgn ? $signed(d) < $signed(mn) : d < mn;
    gt = sgn ? $signed(d) > $signed(mx) : d > mx;
  end
  // a clear with a same-edge capture seeds the stats with that sample
  always_ff @(posedge debug_char_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      valid <= 1'b0;
      mn <= '0;
      mx <= '0;
    end else if (clr || (cap && !valid)) begin
      valid <= cap;
      mn <= cap ? d : '0;
      mx <= cap ? d : '0;
    end else if (cap) begin
      if (lt) mn <= d;
      if (gt) mx <= d;
    end
endmodule

// File: rtl/debug_probe_bank.sv
// debug_probe_bank: snapshot, min/max, history and trigger/freeze control for on-screen debug channels
module debug_probe_bank #(
  parameter int SEQ_LEN = debug_pkg::DEF_SEQ_LEN,
  parameter int CH_NUM = debug_pkg::DEF_CH_NUM,
  parameter int HIST_DEPTH = 8,
  parameter int POST_TRIG = 4,
  parameter int PAGE_SIZE = 4
) (
  input logic debug_char_clk,
  input logic sys_rst_n,
  debug_probe_bank_if.slave bus
);
  import debug_pkg::*;
  localparam int CH_W = sel_w(CH_NUM);
  localparam int HW = $clog2(HIST_DEPTH + 1);
  localparam int PW = $clog2(POST_TRIG + 2);
  state_t state;
  logic [CH_NUM*SEQ_LEN-1:0] snap;
  logic [SEQ_LEN-1:0] ch [CH_NUM];
  logic [SEQ_LEN-1:0] sch [CH_NUM];
  logic [SEQ_LEN-1:0] hist [HIST_DEPTH];
  logic [HW-1:0] hist_cnt;
  logic [PW-1:0] post_cnt;
  logic [CH_W-1:0] hist_ch_q;
  logic [SEQ_LEN-1:0] hist_src;
  logic trig_hit, trig, cap, hist_clr, hit_set, hit_clr;
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign ch[i] = bus.probe_in[i*SEQ_LEN +: SEQ_LEN];
    assign sch[i] = snap[i*SEQ_LEN +: SEQ_LEN];
    probe_stat_cell #(.W(SEQ_LEN)) u_stat (
      .debug_char_clk(debug_char_clk),
      .sys_rst_n(sys_rst_n),
      .clr(bus.clr_stats),
      .cap(cap),
      .sgn(bus.probe_signed[i]),
      .d(ch[i]),
      .mn(bus.min_out[i*SEQ_LEN +: SEQ_LEN]),
      .mx(bus.max_out[i*SEQ_LEN +: SEQ_LEN])
    );
  end
  // arm outranks the trigger, so a trigger only counts on an edge where arm is low
  always_comb begin
    trig = int'(bus.trig_ch) < CH_NUM && ch[bus.trig_ch] == bus.trig_val;
    cap = state != FROZEN && !bus.freeze_req;
    hist_clr = bus.clr_stats || bus.hist_ch != hist_ch_q;
    hist_src = int'(bus.hist_ch) < CH_NUM ? ch[bus.hist_ch] : '0;
    hit_set = state == ARMED && !bus.freeze_req && !bus.arm && trig;
    hit_clr = bus.clr_stats || (bus.arm && !bus.freeze_req && state != POST && !(state == FROZEN && bus.resume));
  end
  always_ff @(posedge debug_char_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= LIVE;
      snap <= '0;
      hist_cnt <= '0;
      post_cnt <= '0;
      hist_ch_q <= '0;
      trig_hit <= 1'b0;
      for (int k = 0; k < HIST_DEPTH; k++) hist[k] <= '0;
    end else begin
      hist_ch_q <= bus.hist_ch;
      trig_hit <= hit_set ? 1'b1 : hit_clr ? 1'b0 : trig_hit;
      if (cap) snap <= bus.probe_in;
      hist[0] <= cap ? hist_src : hist_clr ? '0 : hist[0];
      for (int k = 1; k < HIST_DEPTH; k++) hist[k] <= hist_clr ? '0 : cap ? hist[k-1] : hist[k];
      hist_cnt <= hist_clr ? HW'(cap) : (cap && hist_cnt < HW'(HIST_DEPTH)) ? hist_cnt + 1'b1 : hist_cnt;
      case (state)
        LIVE: begin
          if (bus.freeze_req) state <= FROZEN;
          else if (bus.arm) state <= ARMED;
        end
        ARMED: begin
          if (bus.freeze_req) state <= FROZEN;
          else if (!bus.arm && trig) begin
            state <= POST_TRIG == 0 ? FROZEN : POST;
            post_cnt <= PW'(POST_TRIG);
          end
        end
        POST: begin
          if (bus.freeze_req) state <= FROZEN;
          else begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == PW'(1)) state <= FROZEN;
          end
        end
        default: begin
          if (!bus.freeze_req && bus.resume) state <= LIVE;
          else if (!bus.freeze_req && bus.arm) state <= ARMED;
        end
      endcase
    end
  assign bus.snap_out = snap;
  assign bus.hist_cnt = hist_cnt;
  assign bus.state_out = state;
  assign bus.trig_hit = trig_hit;
  for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_hist
    assign bus.hist_out[k*SEQ_LEN +: SEQ_LEN] = hist[k];
  end
  for (genvar k = 0; k < PAGE_SIZE; k++) begin : g_page
    int idx;
    assign idx = int'(bus.page_sel) * PAGE_SIZE + k;
    assign bus.page_out[k*SEQ_LEN +: SEQ_LEN] = idx < CH_NUM ? sch[CH_W'(idx)] : '0;
  end
endmodule

// File: tb/tb_debug_probe_bank.sv
// tb_debug_probe_bank: scoreboard-driven checks of capture, stats, history, trigger/freeze and paging
module tb_debug_probe_bank;
  localparam int SL = 16, CN = 4, HD = 4, PT = 2, PS = 2;
  localparam int K_SNAP = 0, K_MIN = 1, K_MAX = 2, K_HIST = 3, K_CNT = 4, K_ST = 5, K_HIT = 6, K_PAGE = 7;
  typedef struct {
    string tag;
    int kind;
    int idx;
    logic [15:0] val;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  debug_probe_bank_if #(.SEQ_LEN(SL), .CH_NUM(CN), .HIST_DEPTH(HD), .PAGE_SIZE(PS)) bus();
  debug_probe_bank #(.SEQ_LEN(SL), .CH_NUM(CN), .HIST_DEPTH(HD), .POST_TRIG(PT), .PAGE_SIZE(PS)) dut (
    .debug_char_clk(clk),
    .sys_rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] obs(int kind, int idx);
    case (kind)
      K_SNAP: return bus.snap_out[idx*SL +: SL];
      K_MIN: return bus.min_out[idx*SL +: SL];
      K_MAX: return bus.max_out[idx*SL +: SL];
      K_HIST: return bus.hist_out[idx*SL +: SL];
      K_CNT: return 16'(bus.hist_cnt);
      K_ST: return 16'(bus.state_out);
      K_HIT: return 16'(bus.trig_hit);
      default: return bus.page_out[idx*SL +: SL];
    endcase
  endfunction
  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic want(string tag, int kind, int idx, logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.kind = kind;
    e.idx = idx;
    e.val = v;
    sb.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.kind, e.idx), e.val);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask
  task automatic set_ch(int i, logic [15:0] v);
    bus.probe_in[i*SL +: SL] = v;
  endtask
  initial begin
    bus.probe_in = '0;
    bus.probe_signed = 4'b0010;
    bus.freeze_req = 0;
    bus.resume = 0;
    bus.arm = 0;
    bus.clr_stats = 0;
    bus.trig_ch = 2'd0;
    bus.trig_val = 16'hFFFF;
    bus.hist_ch = 2'd1;
    bus.page_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    want("rst_state", K_ST, 0, 0);
    want("rst_snap1", K_SNAP, 1, 0);
    want("rst_cnt", K_CNT, 0, 0);
    want("rst_hit", K_HIT, 0, 0);
    want("rst_max0", K_MAX, 0, 0);
    want("rst_page0", K_PAGE, 0, 0);
    drain();
    rst_n = 1;
    // signed stream on ch1
    set_ch(1, 16'd5);
    tick();
    set_ch(1, 16'hFFFD);
    tick();
    set_ch(1, 16'd7);
    want("t1_snap1", K_SNAP, 1, 16'd7);
    want("t1_min1", K_MIN, 1, 16'hFFFD);
    want("t1_max1", K_MAX, 1, 16'd7);
    want("t1_h0", K_HIST, 0, 16'd7);
    want("t1_h1", K_HIST, 1, 16'hFFFD);
    want("t1_h2", K_HIST, 2, 16'd5);
    want("t1_h3", K_HIST, 3, 16'd0);
    want("t1_cnt", K_CNT, 0, 16'd3);
    want("t1_state", K_ST, 0, 16'd0);
    tick();
    // unsigned stream, restarted by clr_stats
    bus.probe_signed = 4'b0000;
    bus.clr_stats = 1;
    set_ch(1, 16'd5);
    want("t2_clr_min1", K_MIN, 1, 16'd5);
    want("t2_clr_max1", K_MAX, 1, 16'd5);
    want("t2_clr_cnt", K_CNT, 0, 16'd1);
    tick();
    bus.clr_stats = 0;
    set_ch(1, 16'hFFFD);
    tick();
    set_ch(1, 16'd7);
    want("t2_min1", K_MIN, 1, 16'd5);
    want("t2_max1", K_MAX, 1, 16'hFFFD);
    want("t2_h0", K_HIST, 0, 16'd7);
    want("t2_h1", K_HIST, 1, 16'hFFFD);
    want("t2_cnt", K_CNT, 0, 16'd3);
    tick();
    // arm, trigger on ch2 == 0x10, two post samples then freeze
    bus.arm = 1;
    bus.trig_ch = 2'd2;
    bus.trig_val = 16'h0010;
    set_ch(2, 16'h000E);
    want("t3_armed", K_ST, 0, 16'd1);
    want("t3_hit0", K_HIT, 0, 16'd0);
    tick();
    bus.arm = 0;
    set_ch(2, 16'h000F);
    want("t3_pre_st", K_ST, 0, 16'd1);
    want("t3_pre_hit", K_HIT, 0, 16'd0);
    want("t3_pre_snap", K_SNAP, 2, 16'h000F);
    tick();
    set_ch(2, 16'h0010);
    want("t3_trig_hit", K_HIT, 0, 16'd1);
    want("t3_trig_st", K_ST, 0, 16'd2);
    tick();
    set_ch(2, 16'h0011);
    want("t3_post_st", K_ST, 0, 16'd2);
    want("t3_post_snap", K_SNAP, 2, 16'h0011);
    tick();
    set_ch(2, 16'h0012);
    want("t3_frz_st", K_ST, 0, 16'd3);
    want("t3_frz_snap", K_SNAP, 2, 16'h0012);
    tick();
    set_ch(2, 16'h0013);
    want("t3_hold_snap", K_SNAP, 2, 16'h0012);
    want("t3_hold_cnt", K_CNT, 0, 16'd4);
    tick();
    set_ch(2, 16'h0014);
    want("t3_hold2_snap", K_SNAP, 2, 16'h0012);
    want("t3_max2", K_MAX, 2, 16'h0012);
    want("t3_min2", K_MIN, 2, 16'h0000);
    want("t3_hold_st", K_ST, 0, 16'd3);
    tick();
    // freeze_req blocks resume; then resume to LIVE without capture
    bus.freeze_req = 1;
    bus.resume = 1;
    set_ch(2, 16'h0020);
    want("t4_block_st", K_ST, 0, 16'd3);
    want("t4_block_snap", K_SNAP, 2, 16'h0012);
    tick();
    bus.freeze_req = 0;
    want("t4_live_st", K_ST, 0, 16'd0);
    want("t4_live_snap", K_SNAP, 2, 16'h0012);
    want("t4_live_hit", K_HIT, 0, 16'd1);
    tick();
    bus.resume = 0;
    want("t4_cap_snap", K_SNAP, 2, 16'h0020);
    want("t4_cap_st", K_ST, 0, 16'd0);
    tick();
    // clear with same-edge capture, then history channel switch
    bus.clr_stats = 1;
    set_ch(0, 16'd9);
    want("t5_min0", K_MIN, 0, 16'd9);
    want("t5_max0", K_MAX, 0, 16'd9);
    want("t5_cnt", K_CNT, 0, 16'd1);
    want("t5_h0", K_HIST, 0, 16'd7);
    want("t5_h1", K_HIST, 1, 16'd0);
    want("t5_hit", K_HIT, 0, 16'd0);
    tick();
    bus.clr_stats = 0;
    bus.hist_ch = 2'd3;
    set_ch(3, 16'h0033);
    want("t5_sw_cnt", K_CNT, 0, 16'd1);
    want("t5_sw_h0", K_HIST, 0, 16'h0033);
    want("t5_sw_h1", K_HIST, 1, 16'd0);
    tick();
    set_ch(3, 16'h0044);
    want("t5_sw2_cnt", K_CNT, 0, 16'd2);
    want("t5_sw2_h0", K_HIST, 0, 16'h0044);
    want("t5_sw2_h1", K_HIST, 1, 16'h0033);
    want("t5_min0_keep", K_MIN, 0, 16'd9);
    tick();
    // paging is combinational
    bus.page_sel = 2'd1;
    #1;
    want("t6_p1_s0", K_PAGE, 0, 16'h0020);
    want("t6_p1_s1", K_PAGE, 1, 16'h0044);
    drain();
    bus.page_sel = 2'd0;
    #1;
    want("t6_p0_s0", K_PAGE, 0, 16'd9);
    want("t6_p0_s1", K_PAGE, 1, 16'd7);
    drain();
    bus.page_sel = 2'd2;
    #1;
    want("t6_p2_s0", K_PAGE, 0, 16'd0);
    want("t6_p2_s1", K_PAGE, 1, 16'd0);
    drain();
    bus.page_sel = 2'd1;
    // async reset while in POST
    bus.arm = 1;
    bus.trig_val = 16'h0050;
    set_ch(2, 16'h0050);
    want("t6_armed", K_ST, 0, 16'd1);
    tick();
    bus.arm = 0;
    want("t6_post", K_ST, 0, 16'd2);
    want("t6_post_hit", K_HIT, 0, 16'd1);
    tick();
    #2;
    rst_n = 0;
    #1;
    want("t6_rst_st", K_ST, 0, 16'd0);
    want("t6_rst_snap2", K_SNAP, 2, 16'd0);
    want("t6_rst_min0", K_MIN, 0, 16'd0);
    want("t6_rst_max2", K_MAX, 2, 16'd0);
    want("t6_rst_h0", K_HIST, 0, 16'd0);
    want("t6_rst_cnt", K_CNT, 0, 16'd0);
    want("t6_rst_hit", K_HIT, 0, 16'd0);
    want("t6_rst_page", K_PAGE, 0, 16'd0);
    drain();
    #2;
    rst_n = 1;
    want("t6_after_st", K_ST, 0, 16'd0);
    want("t6_after_snap2", K_SNAP, 2, 16'h0050);
    want("t6_after_min2", K_MIN, 2, 16'h0050);
    want("t6_after_cnt", K_CNT, 0, 16'd1);
    want("t6_after_h0", K_HIST, 0, 16'h0044);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
